// File: rtl/pe_decoder_seq_pkg.sv
// Shared definitions for the sequential 2-to-4 decoder: FSM encodings and count limits.
package pe_decoder_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [7:0] ACC_MAX = 8'd255;
  localparam int         HOLD_W  = 4;
endpackage

// File: rtl/pe_decoder_seq_dec2to4.sv
// Combinational 2-to-4 line decoder; an inactive encoder result decodes to no lines.
module dec2to4 (
  input  logic [1:0] code_i,
  input  logic       v_i,
  output logic [3:0] onehot_o
);
  always_comb begin
    onehot_o = 4'b0000;
    if (v_i) onehot_o[code_i] = 1'b1;
  end
endmodule

// File: rtl/pe_decoder_seq.sv
// Sequential decoder: accepts encoder results, presents the one-hot word for at least
// HOLD_CYCLES cycles until acknowledged, and tracks seen lines and accepted count.
module pe_decoder_seq
  import pe_decoder_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_code,
  input  logic       in_v,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_onehot,
  output logic [3:0] seen_mask,
  input  logic       clr_seen,
  output logic [7:0] accept_cnt
);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == ACC_MAX) ? c : c + 8'd1;
  endfunction

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        word_q, word_d;
  logic              out_valid_q;
  logic [3:0]        seen_q, seen_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        dec_word;
  logic              accept;

  dec2to4 u_dec (
    .code_i   (in_code),
    .v_i      (in_v),
    .onehot_o (dec_word)
  );

  // in_ready is the only combinational output; it is forced low while rst is asserted.
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_ready && in_valid;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    word_d     = word_q;
    seen_d     = seen_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d     = dec_word;
          hold_cnt_d = HOLD_LOAD;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = out_ready ? ST_IDLE : ST_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      seen_d = (clr_seen ? 4'b0000 : seen_q) | dec_word;
      cnt_d  = sat_inc(cnt_q);
    end else if (clr_seen) begin
      seen_d = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      word_q      <= 4'b0000;
      out_valid_q <= 1'b0;
      seen_q      <= 4'b0000;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      word_q      <= word_d;
      out_valid_q <= (state_d != ST_IDLE);
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = word_q;
  assign seen_mask  = seen_q;
  assign accept_cnt = cnt_q;
endmodule
